// File: rtl/voice_pkg.sv
// Shared voice-control types: command enum, bridge register map and
// STATUS field layout. Used by the state controller and arm_cmd_bridge.
package voice_pkg;

  typedef enum logic [2:0] {
    CMD_WELCOME   = 3'd0,
    CMD_RECORDING = 3'd1,
    CMD_UP        = 3'd2,
    CMD_DOWN      = 3'd3,
    CMD_LEFT      = 3'd4,
    CMD_RIGHT     = 3'd5,
    CMD_STOP      = 3'd6,
    CMD_SILENCE   = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_CAPTURE = 2'd2
  } bridge_st_e;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_RESULT = 2'd2;
  localparam logic [1:0] ADDR_THRESH = 2'd3;

  localparam int CTRL_ACK    = 0;
  localparam int CTRL_CLR_TO = 1;
  localparam int CTRL_ABORT  = 2;

  localparam int STAT_PEND    = 0;
  localparam int STAT_BUSY    = 1;
  localparam int STAT_TO      = 2;
  localparam int STAT_CMD_LSB = 4;

  // Classes 0/1 are non-keywords; low confidence is also reported as silence.
  function automatic cmd_e map_class(
    input logic [2:0] cls,
    input logic       low_conf
  );
    if (low_conf || cls < 3'd2) return CMD_SILENCE;
    return cmd_e'(cls);
  endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// Inference watchdog: counts while enabled, flags the final cycle
// of the TIMEOUT_CYC window.
module cmd_timeout_timer #(
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign expire = en && (cnt_q == LAST);

endmodule

// File: rtl/arm_cmd_bridge.sv
// Record-request / keyword-result bridge to the HPS slave port.
// ARM_CMD_CONF_GATE_EN enables confidence gating and the THRESH register.
module arm_cmd_bridge
  import voice_pkg::*;
#(
  parameter int          TIMEOUT_CYC     = 50_000_000,
  parameter logic [7:0]  CONF_THRESH_DEF = 8'd128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rec_req,
  input  logic [1:0]  addr,
  input  logic        wr,
  input  logic        rd,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        irq,
  output logic [2:0]  cmd,
  output logic        cmd_valid
);

  bridge_st_e  state_q;
  cmd_e        cmd_q;
  logic        cmd_valid_q;
  logic        irq_q;
  logic        sticky_q;
  logic [15:0] rdata_q;
  logic        prev_q;
  logic        edge_q;
  logic        expire;
  logic        low_conf;
  logic [15:0] rd_data;

  logic ctrl_wr, res_wr, ack, abort, clr_to;
  assign ctrl_wr = wr && (addr == ADDR_CTRL);
  assign res_wr  = wr && (addr == ADDR_RESULT);
  assign ack     = ctrl_wr && wdata[CTRL_ACK];
  assign abort   = ctrl_wr && wdata[CTRL_ABORT];
  assign clr_to  = ctrl_wr && wdata[CTRL_CLR_TO];

`ifdef ARM_CMD_CONF_GATE_EN
  logic [7:0] thresh_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      thresh_q <= CONF_THRESH_DEF;
    end else if (wr && addr == ADDR_THRESH) begin
      thresh_q <= wdata[7:0];
    end
  end

  assign low_conf = wdata[15:8] < thresh_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{wdata[15:3], CONF_THRESH_DEF};
  assign low_conf   = 1'b0;
`endif

  cmd_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == ST_IDLE && edge_q),
    .en     (state_q != ST_IDLE),
    .expire (expire)
  );

  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_STATUS: begin
        rd_data[STAT_PEND] = (state_q == ST_REQ);
        rd_data[STAT_BUSY] = (state_q == ST_CAPTURE);
        rd_data[STAT_TO]   = sticky_q;
        rd_data[STAT_CMD_LSB +: 3] = cmd_q;
      end
`ifdef ARM_CMD_CONF_GATE_EN
      ADDR_THRESH: rd_data[7:0] = thresh_q;
`endif
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= CMD_WELCOME;
      cmd_valid_q <= 1'b0;
      irq_q       <= 1'b0;
      sticky_q    <= 1'b0;
      rdata_q     <= '0;
      prev_q      <= 1'b1;
      edge_q      <= 1'b0;
    end else begin
      prev_q      <= rec_req;
      edge_q      <= rec_req && !prev_q;
      cmd_valid_q <= 1'b0;
      if (rd) rdata_q <= rd_data;
      if (clr_to) sticky_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (edge_q) begin
            state_q <= ST_REQ;
            irq_q   <= 1'b1;
          end
        end
        ST_REQ, ST_CAPTURE: begin
          if (abort) begin
            state_q <= ST_IDLE;
            irq_q   <= 1'b0;
          end else if (ack && state_q == ST_REQ) begin
            state_q <= ST_CAPTURE;
            irq_q   <= 1'b0;
            cmd_q   <= CMD_RECORDING;
          end else if (res_wr && state_q == ST_CAPTURE) begin
            state_q     <= ST_IDLE;
            cmd_q       <= map_class(wdata[2:0], low_conf);
            cmd_valid_q <= 1'b1;
          end else if (expire) begin
            state_q     <= ST_IDLE;
            irq_q       <= 1'b0;
            cmd_q       <= CMD_SILENCE;
            cmd_valid_q <= 1'b1;
            sticky_q    <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rdata     = rdata_q;
  assign irq       = irq_q;
  assign cmd       = cmd_q;
  assign cmd_valid = cmd_valid_q;

endmodule

// File: doc/arm_cmd_bridge.md
# arm_cmd_bridge

- Sits between the voice state controller and the ARM/HPS running keyword inference; this is the other end of the record/command interface.
- Turns the controller's record request into a request/acknowledge handshake on a 4-register slave port.
- Collects the classified keyword the HPS writes back, gates it by confidence and times out stalled inferences.
- Presents the 3-bit command plus a one-cycle valid strobe to the controller.

## Interface
- TIMEOUT_CYC, 50_000_000: cycles allowed from request to result (1 s at 50 MHz); must be ≥ 2.
- CONF_THRESH_DEF, 8'd128: reset value of the confidence threshold register.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  one clock; reset is synchronous and active-high.
- rec_req  in  1  level request from the state controller (high while in RECORDING).
- addr  in  2  register address.
- wr  in  1  write strobe, one cycle per write.
- rd  in  1  read strobe.
- wdata  in  16  write data.
- rdata  out  16  read data, registered.
- irq  out  1  high while a request awaits HPS acknowledge.
- cmd  out  3  command to the controller, same encoding as the shared command enum.
- cmd_valid  out  1  one-cycle pulse when cmd takes a new result value.

## Operation
- Registers:
  - 0 STATUS, read-only: [0] pending, [1] busy, [2] timeout_sticky, [6:4] cmd.
  - 1 CTRL, write-only: [0] ACK, [1] CLR_TIMEOUT, [2] ABORT.
  - 2 RESULT, write-only: [2:0] class, [15:8] confidence.
  - 3 THRESH, read/write: [7:0].
  - Reads of write-only registers return 0.
- Edge detect: a rising edge of rec_req is registered one cycle (prev flop resets to 1). The edge is accepted only in IDLE; otherwise it is dropped.
- FSM states:
  - IDLE → REQ on an accepted edge.
  - REQ: irq=1, pending=1.
    - CTRL.ACK write → CAPTURE, cmd=RECORDING(1).
  - CAPTURE: busy=1.
    - RESULT write → IDLE, cmd=mapped class, cmd_valid=1.
  - REQ or CAPTURE:
    - Timer expiry → IDLE, cmd=SILENCE(7), cmd_valid=1, timeout_sticky=1.
    - CTRL.ABORT → IDLE, cmd unchanged, no cmd_valid.
- Class mapping:
  - Classes 2..7 pass through.
  - Classes 0 and 1 (not keywords) map to SILENCE.
  - With gating, confidence < THRESH maps to SILENCE; equal passes.
- Ignored writes:
  - ACK outside REQ.
  - RESULT outside CAPTURE.
  - CLR_TIMEOUT clears the sticky bit in any state.
- Timer:
  - Loads 0 on entry to REQ and keeps counting through CAPTURE (it is not restarted on ACK).
  - Expires when the count reaches TIMEOUT_CYC-1.
  - Width is $clog2(TIMEOUT_CYC).
- Simultaneous events, in priority order:
  - rst first.
  - Then ABORT.
  - Then RESULT/ACK.
  - Then timeout. A RESULT in the expiry cycle wins; timeout_sticky is not set.
- Simultaneous wr and rd: both are serviced. A read of STATUS returns the pre-write value.

## Timing
- Reset values:
  - cmd=WELCOME(0), cmd_valid=0, irq=0, rdata=0.
  - State IDLE, THRESH=CONF_THRESH_DEF, sticky=0, timer=0.
- Reset mid-operation: rst asserted in any state returns everything to the reset values on the next edge; no cmd_valid.
- Latencies:
  - rec_req rise to irq=1: 2 cycles (edge register, then state register).
  - ACK write (cycle N) to cmd=1: visible at N+1.
  - RESULT write (cycle N) to cmd and cmd_valid: visible at N+1. cmd_valid is high exactly one cycle.
  - rd at cycle N: rdata valid at N+1 and held until the next rd.
- cmd, irq and cmd_valid are driven directly from flops. No combinational path from slave inputs to outputs.

## Configuration
- ARM_CMD_CONF_GATE_EN:
  - Defined: confidence compared against THRESH, and THRESH is read/write.
  - Undefined: the confidence field is ignored, THRESH reads 0, writes to it are dropped, and the THRESH flops are not built.

## Structure
- Shared package voice_pkg holds:
  - The command enum (WELCOME..SILENCE), also imported by the state controller.
  - Register address constants and CTRL bit indices.
  - The STATUS field positions.
- One sub-module: cmd_timeout_timer (clear, enable, expire pulse, parameter TIMEOUT_CYC).

## Test plan
- Reset: after rst, cmd=0, irq=0, cmd_valid=0, and a STATUS read gives 0x0000.
- Normal cycle:
  - Pulse rec_req → irq=1 two cycles later.
  - Write CTRL=0x0001 → cmd=1.
  - Write RESULT=0xC802 (conf 200, class UP) → cmd=2 with a one-cycle cmd_valid; STATUS=0x0020.
- Gating (macro defined, THRESH=128):
  - RESULT=0x3203 (conf 50) → cmd=7.
  - RESULT=0x8003 (conf 128) → cmd=3.
- Timeout (TIMEOUT_CYC=100):
  - rec_req edge, no ACK → 100 cycles after REQ entry, cmd=7, cmd_valid pulse, STATUS[2]=1, irq=0.
  - Write CTRL=0x0002 → STATUS[2]=0.
- Collision: a RESULT class 4 write in the timer expiry cycle → cmd=4, STATUS[2]=0.
- Abort and reset:
  - CTRL=0x0004 in CAPTURE → IDLE, cmd stays 1, no cmd_valid.
  - rst in CAPTURE → cmd=0 next cycle.
  - A second rec_req edge while busy is ignored (irq stays 0 in CAPTURE).
